// File: rtl/simple_prog_loader.sv
// Byte-stream program loader: assembles high-byte-first word pairs and writes them to sequential RAM addresses.
// Optional running checksum of written words is enabled by defining LOADER_CHECKSUM_EN.
module simple_prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              partial,
  output logic [ADDR_W:0]   word_count,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int                LAST_INT  = BASE_ADDR + DEPTH - 1;
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_INT);

  state_t              state_r, state_s;
  logic [7:0]          hi_r, hi_s;
  logic                pend_r, pend_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [15:0]         wdata_s;
  logic [ADDR_W:0]     count_s;
  logic                full_s, partial_s;
  logic                xfer_s;

  assign byte_ready = (state_r == HI) || (state_r == LO);
  assign ram_we     = (state_r == WRITE);
  assign cpu_hold   = (state_r != IDLE) && (state_r != DONE);
  assign busy       = cpu_hold;
  assign done       = (state_r == DONE);
  assign xfer_s     = byte_valid && byte_ready;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      hi_r       <= 8'h00;
      pend_r     <= 1'b0;
      ram_addr   <= BASE_A;
      ram_wdata  <= 16'h0000;
      word_count <= {(ADDR_W+1){1'b0}};
      full       <= 1'b0;
      partial    <= 1'b0;
    end else begin
      state_r    <= state_s;
      hi_r       <= hi_s;
      pend_r     <= pend_s;
      ram_addr   <= addr_s;
      ram_wdata  <= wdata_s;
      word_count <= count_s;
      full       <= full_s;
      partial    <= partial_s;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_s   = state_r;
    hi_s      = hi_r;
    pend_s    = pend_r;
    addr_s    = ram_addr;
    wdata_s   = ram_wdata;
    count_s   = word_count;
    full_s    = full;
    partial_s = partial;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s   = HI;
          addr_s    = BASE_A;
          count_s   = {(ADDR_W+1){1'b0}};
          full_s    = 1'b0;
          partial_s = 1'b0;
          pend_s    = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      HI: begin
        // finish wins over a byte offered in the same cycle
        if (finish) begin
          state_s   = DONE;
          partial_s = 1'b0;
          pend_s    = 1'b0;
        end else if (xfer_s) begin
          hi_s    = byte_in;
          state_s = LO;
        end else begin
          state_s = HI;
        end
      end
      LO: begin
        if (xfer_s) begin
          wdata_s = {hi_r, byte_in};
          pend_s  = finish;
          state_s = WRITE;
        end else if (finish) begin
          state_s   = DONE;
          partial_s = 1'b1;
        end else begin
          state_s = LO;
        end
      end
      WRITE: begin
        count_s = word_count + (ADDR_W+1)'(1);
        pend_s  = 1'b0;
        if (ram_addr == LAST_ADDR) begin
          state_s = DONE;
          full_s  = 1'b1;
        end else if (pend_r || finish) begin
          state_s = DONE;
          addr_s  = ram_addr + ADDR_W'(1);
        end else begin
          state_s = HI;
          addr_s  = ram_addr + ADDR_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_r;
  logic        sum_clr_s;

  assign sum_clr_s = start && ((state_r == IDLE) || (state_r == DONE));

  // Modulo-2^16 sum of every word, added on the edge that ends WRITE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r <= 16'h0000;
    end else if (sum_clr_s) begin
      sum_r <= 16'h0000;
    end else if (state_r == WRITE) begin
      sum_r <= sum_r + ram_wdata;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign checksum = sum_r;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_simple_prog_loader.sv
// Self-checking bench for simple_prog_loader: randomized byte loads compared against a word-level reference model.
module tb_simple_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, finish, byte_valid, sel;
  logic [7:0]  byte_in;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [11:0] obs_a[$];
  logic [15:0] obs_d[$];

  logic        a_ready, a_we, a_hold, a_busy, a_done, a_full, a_partial;
  logic [11:0] a_addr;
  logic [15:0] a_wdata, a_sum;
  logic [12:0] a_wc;
  logic        f_ready, f_we, f_hold, f_busy, f_done, f_full, f_partial;
  logic [11:0] f_addr;
  logic [15:0] f_wdata, f_sum;
  logic [12:0] f_wc;

  logic        cur_ready, cur_we, cur_hold, cur_busy, cur_done, cur_full, cur_partial;
  logic [11:0] cur_addr;
  logic [15:0] cur_wdata, cur_sum;
  logic [12:0] cur_wc;

  always #5 clk = ~clk;

  simple_prog_loader dut (
    .clk(clk), .reset(reset), .start(start & ~sel), .finish(finish & ~sel),
    .byte_valid(byte_valid & ~sel), .byte_in(byte_in), .byte_ready(a_ready),
    .ram_addr(a_addr), .ram_wdata(a_wdata), .ram_we(a_we), .cpu_hold(a_hold),
    .busy(a_busy), .done(a_done), .full(a_full), .partial(a_partial),
    .word_count(a_wc), .checksum(a_sum)
  );

  simple_prog_loader #(.DEPTH(4)) dut_f (
    .clk(clk), .reset(reset), .start(start & sel), .finish(finish & sel),
    .byte_valid(byte_valid & sel), .byte_in(byte_in), .byte_ready(f_ready),
    .ram_addr(f_addr), .ram_wdata(f_wdata), .ram_we(f_we), .cpu_hold(f_hold),
    .busy(f_busy), .done(f_done), .full(f_full), .partial(f_partial),
    .word_count(f_wc), .checksum(f_sum)
  );

  assign cur_ready   = sel ? f_ready   : a_ready;
  assign cur_we      = sel ? f_we      : a_we;
  assign cur_hold    = sel ? f_hold    : a_hold;
  assign cur_busy    = sel ? f_busy    : a_busy;
  assign cur_done    = sel ? f_done    : a_done;
  assign cur_full    = sel ? f_full    : a_full;
  assign cur_partial = sel ? f_partial : a_partial;
  assign cur_addr    = sel ? f_addr    : a_addr;
  assign cur_wdata   = sel ? f_wdata   : a_wdata;
  assign cur_sum     = sel ? f_sum     : a_sum;
  assign cur_wc      = sel ? f_wc      : a_wc;

  // Record every RAM write of the selected instance
  always @(negedge clk) begin
    if (cur_we) begin
      obs_a.push_back(cur_addr);
      obs_d.push_back(cur_wdata);
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_finish();
    @(negedge clk); finish = 1'b1;
    @(negedge clk); finish = 1'b0;
  endtask

  // Offer one byte; ok reports whether it was taken within the bound
  task automatic send_byte(input logic [7:0] b, input bit fin, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1; byte_in = b; finish = fin;
    for (int i = 0; i < 6; i++) begin
      if (cur_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    byte_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic check_zero(input string name);
    logic [63:0] v;
    v = {cur_ready, cur_we, cur_hold, cur_busy, cur_done, cur_full, cur_partial,
         cur_wc, cur_addr, cur_wdata, cur_sum};
    total_cnt++;
    if (v !== 64'h0) $display("FAIL %s: outputs=%h required 0", name, v);
    else pass_cnt++;
  endtask

  // Run one load and check it against the word-level model
  task automatic run_load(input string name, input logic [7:0] bytes[$], input int depth,
                          input bit poke, input bit fin_last);
    int n, acc, nw, exp_acc;
    bit ok, exp_full, exp_partial;
    logic [15:0] w, exp_sum;
    n = bytes.size(); acc = 0; exp_sum = 16'h0;
    obs_a.delete(); obs_d.delete();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[i], fin_last && (i == n - 1), 1'b1, ok);
      if (ok) acc++;
      if (poke && i == 0) pulse_start();
    end
    if (!cur_done) pulse_finish();
    for (int i = 0; i < 20 && !cur_done; i++) @(negedge clk);
    @(negedge clk);

    nw          = (n / 2 < depth) ? n / 2 : depth;
    exp_full    = (n / 2 >= depth);
    exp_partial = !exp_full && (n % 2 == 1);
    exp_acc     = (n < 2 * depth) ? n : 2 * depth;

    total_cnt++;
    if (cur_done !== 1'b1) $display("FAIL %s done: got %b want 1", name, cur_done);
    else pass_cnt++;
    total_cnt++;
    if (obs_a.size() != nw) $display("FAIL %s write_count: got %0d want %0d", name, obs_a.size(), nw);
    else pass_cnt++;
    for (int i = 0; i < nw && i < obs_a.size(); i++) begin
      w = {bytes[2*i], bytes[2*i+1]};
      exp_sum = exp_sum + w;
      total_cnt++;
      if (obs_a[i] !== 12'(i) || obs_d[i] !== w)
        $display("FAIL %s write%0d: got %h@%h want %h@%h", name, i, obs_d[i], obs_a[i], w, 12'(i));
      else pass_cnt++;
    end
`ifndef LOADER_CHECKSUM_EN
    exp_sum = 16'h0;
`endif
    total_cnt++;
    if (cur_wc !== 13'(nw) || cur_full !== exp_full || cur_partial !== exp_partial || cur_busy !== 1'b0)
      $display("FAIL %s status: wc=%0d full=%b partial=%b busy=%b want wc=%0d full=%b partial=%b busy=0",
               name, cur_wc, cur_full, cur_partial, cur_busy, nw, exp_full, exp_partial);
    else pass_cnt++;
    total_cnt++;
    if (cur_sum !== exp_sum) $display("FAIL %s checksum: got %h want %h", name, cur_sum, exp_sum);
    else pass_cnt++;
    total_cnt++;
    if (acc != exp_acc) $display("FAIL %s accepted: got %0d want %0d", name, acc, exp_acc);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
  endtask

  task automatic test_three_words();
    logic [7:0] b[$];
    b = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
    run_load("three_words", b, 4096, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    total_cnt++;
    if (cur_sum !== 16'hBE00) $display("FAIL three_words_sum: got %h want BE00", cur_sum);
    else pass_cnt++;
`endif
  endtask

  task automatic test_odd();
    logic [7:0] b[$];
    b = '{8'h11, 8'h22, 8'h33};
    run_load("odd", b, 4096, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    logic [7:0] b[$];
    sel = 1'b1;
    for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
    run_load("full", b, 4, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_finish_with_low();
    logic [7:0] b[$];
    b = '{8'h5A, 8'hA5};
    run_load("finish_low", b, 4096, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    bit ok;
    obs_a.delete(); obs_d.delete();
    pulse_start();
    send_byte(8'h77, 1'b0, 1'b0, ok);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_held");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_mid_after");
    total_cnt++;
    if (obs_a.size() != 0) $display("FAIL reset_mid_writes: got %0d want 0", obs_a.size());
    else pass_cnt++;
    b = '{8'hC3, 8'h3C};
    run_load("reset_mid_reload", b, 4096, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    int n;
    bit fl;
    for (int t = 0; t < 6; t++) begin
      b.delete();
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      fl = (n > 0) && (n % 2 == 0) && ($urandom_range(0, 1) == 1);
      run_load($sformatf("random%0d", t), b, 4096, 1'($urandom_range(0, 1)), fl);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    run_load("back_to_back", b, 4096, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_odd();
    test_full();
    test_finish_with_low();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
